// File: rtl/pc_select_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_select_if
// Handshake / bus bundle between the PC select register and its controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface pc_select_if #(
   parameter int W = 32
);
   logic [1:0]     sel;
   logic [2*W-1:0] BrA;
   logic [W-1:0]   Bus_A;
   logic           trap;
   logic           stall;
   logic           pc_ready;
   logic [W-1:0]   pc_out;
   logic           pc_valid;
   logic           misalign;

   // Controller / fetch side: drives requests, observes the PC
   modport master (
      output sel, BrA, Bus_A, trap, stall, pc_ready,
      input  pc_out, pc_valid, misalign
   );

   // PC register side
   modport slave (
      input  sel, BrA, Bus_A, trap, stall, pc_ready,
      output pc_out, pc_valid, misalign
   );
endinterface
`default_nettype wire

// File: rtl/pc_select_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_select_reg
// Registered program counter with sequential/branch/bus/trap source select,
// stall handling with a pending-redirect buffer, and target alignment check.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pc_select_reg #(
   parameter int           W          = 32,
   parameter int           INC        = 4,
   parameter logic [W-1:0] RESET_PC   = '0,
   parameter logic [W-1:0] TRAP_VEC   = W'(32'h0000_0080),
   parameter int           ALIGN_BITS = 2
) (
   input  wire logic       clk,
   input  wire logic       rst_n,
   pc_select_if.slave      bus
);

   // Bits that survive alignment; the cleared low bits are the ones checked
   localparam logic [W-1:0] ALIGN_MASK = ~((W'(1) << ALIGN_BITS) - W'(1));
   localparam logic [W-1:0] INC_W      = W'(INC);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t       state_q;
   logic [W-1:0] pc_q;
   logic         valid_q;
   logic         mis_q;
   logic         pend_q;
   logic         pend_trap_q;
   logic [W-1:0] pend_pc_q;

   logic [W-1:0] redir_tgt;
   logic         redirect;
   logic [W-1:0] redir_aligned;
   logic         redir_mis;
   logic [W-1:0] pend_aligned;
   logic         pend_mis;
   logic         pend_d;
   logic         pend_trap_d;
   logic [W-1:0] pend_pc_d;

   // Redirect target selection and alignment of both redirect and pending targets
   always_comb begin
      redir_tgt = '0;
      case (bus.sel)
         2'b01:   redir_tgt = bus.BrA[W-1:0];
         2'b10:   redir_tgt = bus.Bus_A;
         2'b11:   redir_tgt = bus.BrA[2*W-1:W];
         default: redir_tgt = '0;
      endcase
      redirect      = (bus.sel != 2'b00);
      redir_aligned = redir_tgt & ALIGN_MASK;
      redir_mis     = |(redir_tgt & ~ALIGN_MASK);
      pend_aligned  = pend_pc_q & ALIGN_MASK;
      // A pending trap carries TRAP_VEC, which is never flagged
      pend_mis      = !pend_trap_q && (|(pend_pc_q & ~ALIGN_MASK));
   end

   // Pending-buffer update used while stalled: a trap locks the buffer,
   // later redirects only overwrite earlier redirects
   always_comb begin
      pend_d      = pend_q;
      pend_trap_d = pend_trap_q;
      pend_pc_d   = pend_pc_q;
      if (bus.trap) begin
         pend_d      = 1'b1;
         pend_trap_d = 1'b1;
         pend_pc_d   = TRAP_VEC;
      end else if (redirect) begin
         pend_d = 1'b1;
         if (!pend_trap_q) begin
            pend_pc_d = redir_tgt;
         end
      end
   end

   // PC state machine with registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         valid_q     <= 1'b0;
         mis_q       <= 1'b0;
         pend_q      <= 1'b0;
         pend_trap_q <= 1'b0;
         pend_pc_q   <= '0;
      end else begin
         mis_q <= 1'b0;
         case (state_q)
            BOOT: begin
               state_q <= RUN;
               valid_q <= 1'b1;
            end
            RUN: begin
               if (bus.stall) begin
                  state_q     <= HOLD;
                  valid_q     <= 1'b0;
                  pend_q      <= pend_d;
                  pend_trap_q <= pend_trap_d;
                  pend_pc_q   <= pend_pc_d;
               end else if (bus.trap) begin
                  pc_q <= TRAP_VEC;
               end else if (redirect) begin
                  pc_q  <= redir_aligned;
                  mis_q <= redir_mis;
               end else if (bus.pc_ready) begin
                  pc_q <= pc_q + INC_W;
               end
            end
            HOLD: begin
               if (bus.stall) begin
                  pend_q      <= pend_d;
                  pend_trap_q <= pend_trap_d;
                  pend_pc_q   <= pend_pc_d;
               end else begin
                  state_q     <= RUN;
                  valid_q     <= 1'b1;
                  pend_q      <= 1'b0;
                  pend_trap_q <= 1'b0;
                  // A live trap/redirect on release beats the buffered one
                  if (bus.trap) begin
                     pc_q <= TRAP_VEC;
                  end else if (redirect) begin
                     pc_q  <= redir_aligned;
                     mis_q <= redir_mis;
                  end else if (pend_q) begin
                     pc_q  <= pend_aligned;
                     mis_q <= pend_mis;
                  end
               end
            end
            default: begin
               state_q <= BOOT;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.pc_out   = pc_q;
   assign bus.pc_valid = valid_q;
   assign bus.misalign = mis_q;

endmodule
`default_nettype wire

// File: doc/pc_select_reg.md
PC_SELECT_REG -- requirements
Module: pc_select_reg

Interface
REQ-001 Parameter W, default 32, PC and target width in bits.
REQ-002 Parameter INC, default 4, sequential PC increment.
REQ-003 Parameter RESET_PC, default 0, PC value loaded by reset.
REQ-004 Parameter TRAP_VEC, default 32'h0000_0080, PC loaded on trap.
REQ-005 Parameter ALIGN_BITS, default 2, low target bits that must be zero.
REQ-006 The block SHALL use one clock; reset is synchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst_n  in  1  synchronous active-low reset.
REQ-009 sel  in  2  source select: 00 sequential, 01 BrA[W-1:0], 10 Bus_A, 11 BrA[2W-1:W].
REQ-010 BrA  in  2W  packed dual branch target.
REQ-011 Bus_A  in  W  register-bus jump target.
REQ-012 trap  in  1  trap request, highest priority.
REQ-013 stall  in  1  pipeline stall request.
REQ-014 pc_ready  in  1  fetch accepts pc_out this cycle.
REQ-015 pc_out  out  W  registered current PC.
REQ-016 pc_valid  out  1  pc_out is a valid fetch address.
REQ-017 misalign  out  1  one-cycle pulse: loaded target had nonzero low ALIGN_BITS.

Function
REQ-018 Redirect means sel != 00 in a cycle; sel = 00 is never a redirect, unlike a hold.
REQ-019 State machine SHALL have states BOOT, RUN, HOLD.
REQ-020 BOOT: pc_out = RESET_PC, pc_valid = 0; next cycle unconditionally RUN.
REQ-021 RUN, stall = 0: pc_valid = 1; next pc_out priority: trap -> TRAP_VEC; else redirect -> selected target; else pc_ready = 1 -> pc_out + INC; else hold.
REQ-022 A redirect or trap in RUN SHALL take effect at the next edge regardless of pc_ready.
REQ-023 RUN, stall = 1: next state HOLD, pc_out held; concurrent trap/redirect captured into pending register per REQ-025.
REQ-024 HOLD: pc_valid = 0, pc_out held; remain while stall = 1.
REQ-025 Pending capture: trap sets pend_pc = TRAP_VEC, pend_trap = 1; redirect sets pend_pc = target only if pend_trap = 0; later redirect overwrites earlier redirect; pend = 1 on any capture.
REQ-026 HOLD, stall = 0: next state RUN; if pend = 1, pc_out <= pend_pc and pend, pend_trap cleared; else pc_out held; a trap/redirect in this same cycle overrides pend per REQ-021 priority.
REQ-027 Loaded targets (redirect or pending) SHALL have low ALIGN_BITS forced to zero; misalign pulses in the cycle after the load if any were nonzero; TRAP_VEC and RESET_PC are never flagged.
REQ-028 Sequential increment SHALL wrap modulo 2^W (e.g. W=32: FFFF_FFFC + 4 -> 0000_0000), no flag.
REQ-029 pc_out SHALL never change while pc_valid = 1 and pc_ready = 0 except by trap or redirect.
REQ-030 Latency: every source reaches pc_out exactly one edge after acceptance; no combinational path from inputs to outputs.

Reset
REQ-031 rst_n = 0 at an edge SHALL set state BOOT, pc_out = RESET_PC, pc_valid = 0, misalign = 0, pend = 0, pend_trap = 0, pend_pc = 0.
REQ-032 Reset asserted mid-HOLD with pending redirect SHALL discard the pending redirect.
REQ-033 Reset dominates trap, stall and redirect in the same cycle.

Verification
REQ-034 Reset release, sel=00, pc_ready=1 -> BOOT cycle pc_out=0 valid=0; then 0, 4, 8, 0xC with valid=1.
REQ-035 In RUN at pc 0x10, sel=11, BrA={32'h0000_2000, 32'h0000_1000} -> next pc_out=0x2000; sel=01 -> 0x1000; sel=10, Bus_A=0x3002 -> 0x3000 and misalign=1 one cycle.
REQ-036 In RUN, stall=1 with sel=10 Bus_A=0x400, then trap during HOLD, then redirect 0x500, stall released -> pc_out=0x80, valid=1.
REQ-037 pc_ready=0 for 3 cycles at pc 0x20, sel=00 -> pc_out stays 0x20, valid=1; then trap=1, sel=01 same cycle -> 0x80.
REQ-038 pc_out=FFFF_FFFC, pc_ready=1 -> 0000_0000; rst_n=0 during HOLD with pend set -> BOOT, pc_out=0, pending lost after release.
